stall_bus_fifo: RTL and testbench
=================================

Name: stall_bus_fifo

Overview:
- Parametrised buffering stage for stall-bus traffic: a first-word-fall-through FIFO.
- Upstream producer: data + valid; this block returns an early stall with a configurable skid margin.
- Downstream consumer: data + valid; consumer returns a stall.
- Inserted between stall-bus producers and consumers wherever stall propagation needs registering or traffic must be decoupled; also adds flush and overflow detection.

Parameters:
WIDTH, 8, payload width in bits (>=1)
NUM, 16, storage depth in entries (>=2, need not be a power of 2)
SKID, 2, entries kept in reserve once OUT_stall asserts (0 <= SKID < NUM)

Ports:
clk  input  1  clock; all state changes on posedge clk
rst  input  1  reset; synchronous, active-high
IN_flush  input  1  synchronous clear of contents
IN_data  input  WIDTH  upstream payload
IN_valid  input  1  upstream payload valid
OUT_stall  output  1  stall request to upstream
OUT_data  output  WIDTH  head-of-queue payload
OUT_valid  output  1  head entry valid
IN_stall  input  1  downstream stall
OUT_count  output  $clog2(NUM+1)  current occupancy
OUT_overflow  output  1  sticky: a valid write was dropped

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled only at posedge clk.
- Reset (rst=1 at posedge): rdPtr=0, wrPtr=0, count=0, OUT_overflow=0. Storage contents are not reset.
- Outputs after reset: OUT_valid=0, OUT_stall=0 (when SKID < NUM), OUT_count=0. OUT_data is don't-care while OUT_valid=0.
- Priority: rst > IN_flush > normal operation.
- Flush (IN_flush=1, rst=0):
  - Same effect as reset, including clearing OUT_overflow.
  - A push or pop in the same cycle is ignored.
- Pop:
  - pop = OUT_valid && !IN_stall.
  - OUT_valid = (count != 0).
  - OUT_data = mem[rdPtr], combinational from registered state (FWFT).
- Push:
  - push = IN_valid && (count < NUM || pop).
  - A write into a full FIFO is accepted if a pop happens in the same cycle.
- Drop:
  - If IN_valid && count==NUM && !pop, the data is discarded and OUT_overflow is set to 1.
  - OUT_overflow stays 1 until rst or IN_flush.
- Stall is advisory:
  - OUT_stall = (count >= NUM-SKID), derived from registered count only.
  - Pushes are still accepted while OUT_stall=1 and count<NUM; this is the skid window.
- Pointers: each pointer increments by 1 on its event and wraps from NUM-1 to 0. Modulo NUM, not modulo 2^n.
- count update:
  - +1 on push only, -1 on pop only.
  - Unchanged on push+pop or on neither.
  - count never exceeds NUM and never underflows.
- Latency:
  - A word pushed into an empty FIFO appears on OUT_data/OUT_valid on the cycle after the push edge.
  - No zero-cycle bypass.
- Empty + push + IN_stall: the word is stored; OUT_valid rises next cycle and holds while IN_stall=1.
- Stability: while OUT_valid=1 && IN_stall=1, OUT_data must be stable.
- Ordering: strict FIFO. No reordering, no duplication.
- Assertions (sim only):
  - count <= NUM.
  - OUT_valid == (count != 0).
  - wrPtr == (rdPtr + count) mod NUM.

Test Plan:
- Reset and flush: fill 5 words, assert rst for 1 cycle -> OUT_count=0, OUT_valid=0, OUT_stall=0, OUT_overflow=0. Repeat using IN_flush with IN_valid=1 held in the same cycle -> count=0 (the push is ignored).
- Single word latency: empty FIFO, push 8'hA5 at cycle 0 with IN_stall=0 -> OUT_valid=1, OUT_data=8'hA5 at cycle 1; popped at cycle 1 -> OUT_valid=0 at cycle 2.
- Stall threshold and skid (NUM=16, SKID=2), IN_stall=1:
  - Push 0..13 -> OUT_stall=1 once count=14.
  - Push 14, 15 -> accepted, count=16.
  - Push 16 -> dropped, OUT_overflow=1.
  - Release IN_stall -> outputs 0..15 in order, no 16.
- Full with simultaneous push+pop:
  - Setup: count=16, IN_stall=0, IN_valid=1 with value 8'h77.
  - Required: count stays 16, head advances, OUT_overflow stays 0, 8'h77 emerges as the 16th word after.
- Wrap-around with NUM=5, SKID=0: stream 23 words with random IN_stall (~30%) and random IN_valid -> output sequence equals the accepted input sequence; pointers wrap 4->0; OUT_stall=1 exactly when count=5.
- Reset mid-operation: count=7, push and pop active, rst=1 for one cycle -> next cycle count=0, OUT_valid=0; a subsequent push of 8'h3C is the first word output.

Source files
------------

// File: rtl/stall_bus_fifo.sv
// First-word-fall-through FIFO for stall-bus traffic. It raises an early upstream stall
// that leaves SKID entries of margin, and it flags writes that are dropped when full.
module stall_bus_fifo #(
    parameter int WIDTH = 8,
    parameter int NUM   = 16,
    parameter int SKID  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     IN_flush,
    input  logic [WIDTH-1:0]         IN_data,
    input  logic                     IN_valid,
    output logic                     OUT_stall,
    output logic [WIDTH-1:0]         OUT_data,
    output logic                     OUT_valid,
    input  logic                     IN_stall,
    output logic [$clog2(NUM+1)-1:0] OUT_count,
    output logic                     OUT_overflow
);
    localparam int CW = $clog2(NUM + 1);
    localparam int PW = $clog2(NUM);
    localparam logic [CW-1:0] FULL   = CW'(NUM);
    localparam logic [CW-1:0] THRESH = CW'(NUM - SKID);
    localparam logic [PW-1:0] PLAST  = PW'(NUM - 1);

    logic [WIDTH-1:0] mem [NUM];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             push, pop, drop;

    always_comb begin
        OUT_valid    = (count != '0);
        OUT_stall    = (count >= THRESH);
        OUT_data     = mem[rd_ptr];
        OUT_count    = count;
        OUT_overflow = overflow;
        pop          = OUT_valid && !IN_stall;
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        push         = IN_valid && ((count != FULL) || pop);
        drop         = IN_valid && (count == FULL) && !pop;
    end

    always_ff @(posedge clk) begin
        if (!rst && !IN_flush && push)
            mem[wr_ptr] <= IN_data;
    end

    always_ff @(posedge clk) begin
        if (rst || IN_flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PLAST) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PLAST) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)
                overflow <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    a_count_max: assert property (@(posedge clk) disable iff (rst) count <= FULL);
    a_valid:     assert property (@(posedge clk) disable iff (rst) OUT_valid == (count != '0));
    a_ptrs:      assert property (@(posedge clk) disable iff (rst)
                     int'(wr_ptr) == (int'(rd_ptr) + int'(count)) % NUM);
`endif
endmodule

// File: tb/tb_stall_bus_fifo.sv
// Directed bench for stall_bus_fifo: a default instance (16 entries, skid 2) and a
// 5-entry, zero-skid instance that is driven by a random stream checked against a queue.
module tb_stall_bus_fifo;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, flush, vin, stall;
    logic [7:0] din;
    logic       ostall, ovalid, oovf;
    logic [7:0] odata;
    logic [4:0] ocount;

    logic       rst_b, flush_b, vin_b, stall_b;
    logic [7:0] din_b;
    logic       ostall_b, ovalid_b, oovf_b;
    logic [7:0] odata_b;
    logic [2:0] ocount_b;

    int vectors = 0;
    int miscompares = 0;

    stall_bus_fifo #(.WIDTH(8), .NUM(16), .SKID(2)) dut (
        .clk(clk), .rst(rst), .IN_flush(flush), .IN_data(din), .IN_valid(vin),
        .OUT_stall(ostall), .OUT_data(odata), .OUT_valid(ovalid), .IN_stall(stall),
        .OUT_count(ocount), .OUT_overflow(oovf)
    );

    stall_bus_fifo #(.WIDTH(8), .NUM(5), .SKID(0)) dut5 (
        .clk(clk), .rst(rst_b), .IN_flush(flush_b), .IN_data(din_b), .IN_valid(vin_b),
        .OUT_stall(ostall_b), .OUT_data(odata_b), .OUT_valid(ovalid_b), .IN_stall(stall_b),
        .OUT_count(ocount_b), .OUT_overflow(oovf_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n, input logic [7:0] base);
        vin = 1'b1;
        for (int i = 0; i < n; i++) begin
            din = base + 8'(i);
            tick();
        end
        vin = 1'b0;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_drain[$];
        bit         dropped;
        bit         b_pop, b_push;
        int         sent, received, cycles;

        rst = 1'b1; flush = 1'b0; vin = 1'b0; stall = 1'b1; din = '0;
        rst_b = 1'b1; flush_b = 1'b0; vin_b = 1'b0; stall_b = 1'b1; din_b = '0;
        tick();
        rst = 1'b0; rst_b = 1'b0;
        check("reset_count", 32'(ocount), 0);
        check("reset_valid", 32'(ovalid), 0);
        check("reset_stall", 32'(ostall), 0);
        check("reset_ovf", 32'(oovf), 0);

        // Reset after five words
        push_words(5, 8'h00);
        check("fill5_count", 32'(ocount), 5);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_count", 32'(ocount), 0);
        check("rst_valid", 32'(ovalid), 0);
        check("rst_stall", 32'(ostall), 0);
        check("rst_ovf", 32'(oovf), 0);

        // Flush with a push in the same cycle
        push_words(5, 8'h00);
        flush = 1'b1; vin = 1'b1; din = 8'hEE; tick();
        flush = 1'b0; vin = 1'b0;
        check("flush_count", 32'(ocount), 0);
        check("flush_valid", 32'(ovalid), 0);

        // Single-word latency
        stall = 1'b0; vin = 1'b1; din = 8'hA5;
        check("lat_valid_c0", 32'(ovalid), 0);
        tick(); vin = 1'b0;
        check("lat_valid_c1", 32'(ovalid), 1);
        check("lat_data_c1", 32'(odata), 32'h A5);
        tick();
        check("lat_valid_c2", 32'(ovalid), 0);

        // Stall threshold and skid window
        stall = 1'b1;
        vin = 1'b1;
        for (int i = 0; i < 14; i++) begin
            din = 8'(i);
            tick();
            check("skid_stall", 32'(ostall), (i + 1 >= 14) ? 1 : 0);
        end
        din = 8'd14; tick();
        din = 8'd15; tick();
        check("skid_full_count", 32'(ocount), 16);
        check("skid_full_ovf", 32'(oovf), 0);
        din = 8'd16; tick(); vin = 1'b0;
        check("drop_count", 32'(ocount), 16);
        check("drop_ovf", 32'(oovf), 1);
        stall = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("drain_valid", 32'(ovalid), 1);
            check("drain_data", 32'(odata), 32'(k));
            tick();
        end
        check("drain_empty", 32'(ovalid), 0);
        check("ovf_sticky", 32'(oovf), 1);
        flush = 1'b1; tick(); flush = 1'b0;
        check("flush_ovf", 32'(oovf), 0);

        // Full FIFO with simultaneous push and pop
        stall = 1'b1;
        push_words(16, 8'h10);
        check("pp_full", 32'(ocount), 16);
        stall = 1'b0; vin = 1'b1; din = 8'h77;
        check("pp_head", 32'(odata), 32'h10);
        tick(); vin = 1'b0;
        check("pp_count", 32'(ocount), 16);
        check("pp_ovf", 32'(oovf), 0);
        for (int k = 1; k < 16; k++) exp_drain.push_back(8'h10 + 8'(k));
        exp_drain.push_back(8'h77);
        foreach (exp_drain[k]) begin
            check("pp_drain", 32'(odata), 32'(exp_drain[k]));
            tick();
        end
        check("pp_empty", 32'(ovalid), 0);

        // Reset in the middle of traffic
        stall = 1'b1;
        push_words(7, 8'h40);
        check("mid_count", 32'(ocount), 7);
        stall = 1'b0; vin = 1'b1; din = 8'h99; rst = 1'b1;
        tick(); rst = 1'b0;
        vin = 1'b0; stall = 1'b1;
        check("mid_rst_count", 32'(ocount), 0);
        check("mid_rst_valid", 32'(ovalid), 0);
        vin = 1'b1; din = 8'h3C; tick(); vin = 1'b0;
        check("mid_first_valid", 32'(ovalid), 1);
        check("mid_first_data", 32'(odata), 32'h3C);
        check("mid_first_count", 32'(ocount), 1);

        // Depth-5, zero-skid instance: random stream against a queue model
        dropped = 0; sent = 0; received = 0; cycles = 0;
        while (received < 23 && cycles < 600) begin
            stall_b = ($urandom_range(0, 99) < 30);
            vin_b   = (sent < 23) && ($urandom_range(0, 99) < 70);
            din_b   = 8'($urandom_range(0, 255));
            check("w5_stall", 32'(ostall_b), (q.size() == 5) ? 1 : 0);
            check("w5_count", 32'(ocount_b), 32'(q.size()));
            check("w5_valid", 32'(ovalid_b), (q.size() != 0) ? 1 : 0);
            if (q.size() != 0) check("w5_data", 32'(odata_b), 32'(q[0]));
            b_pop  = (q.size() != 0) && !stall_b;
            b_push = vin_b && ((q.size() < 5) || b_pop);
            if (vin_b && !b_push) dropped = 1;
            tick();
            if (b_pop) begin
                void'(q.pop_front());
                received++;
            end
            if (b_push) begin
                q.push_back(din_b);
                sent++;
            end
            cycles++;
        end
        vin_b = 1'b0;
        check("w5_done", 32'(received), 23);
        check("w5_ovf", 32'(oovf_b), 32'(dropped));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
